// File: rtl/ram_dp_be.sv
// Dual-address RAM: port A read/write with byte enables, port B read-only.
// A clear sequencer zero-fills the array after reset or on request, blocking both ports while busy.
module ram_dp_be #(
    parameter int ADDR_SIZE      = 16,
    parameter int DATA_SIZE      = 32,
    parameter int RD_LATENCY     = 1,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    output logic                   busy,
    input  logic                   en_A,
    input  logic                   w_e_A,
    input  logic [DATA_SIZE/8-1:0] be_A,
    input  logic [ADDR_SIZE-1:0]   addr_A,
    input  logic [DATA_SIZE-1:0]   data_in_A,
    output logic [DATA_SIZE-1:0]   data_out_A,
    output logic                   valid_A,
    input  logic                   en_B,
    input  logic [ADDR_SIZE-1:0]   addr_B,
    output logic [DATA_SIZE-1:0]   data_out_B,
    output logic                   valid_B
);

    localparam int NBYTES = DATA_SIZE / 8;
    localparam int DEPTH  = 2 ** ADDR_SIZE;

    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_badLatency
        $error("ram_dp_be: RD_LATENCY must be 1 or 2");
    end
    if (DATA_SIZE % 8 != 0) begin : g_badWidth
        $error("ram_dp_be: DATA_SIZE must be a multiple of 8");
    end

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t                 r_state;
    state_t                 w_nextState;
    logic [ADDR_SIZE-1:0]   r_clearPtr;
    logic [ADDR_SIZE-1:0]   w_nextPtr;

    logic [DATA_SIZE-1:0]   r_mem [DEPTH];

    logic                   w_accA;
    logic                   w_accB;
    logic                   w_wrA;
    logic [DATA_SIZE-1:0]   w_oldA;
    logic [DATA_SIZE-1:0]   w_oldB;
    logic [DATA_SIZE-1:0]   w_mergedA;
    logic [DATA_SIZE-1:0]   w_rdA;
    logic [DATA_SIZE-1:0]   w_rdB;

    logic                   r_validA1;
    logic                   r_validB1;
    logic [DATA_SIZE-1:0]   r_dataA1;
    logic [DATA_SIZE-1:0]   r_dataB1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
            r_clearPtr <= '0;
        end else begin
            r_state    <= w_nextState;
            r_clearPtr <= w_nextPtr;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_nextPtr   = r_clearPtr;
        case (r_state)
            S_IDLE: begin
                if (clear) begin
                    w_nextState = S_CLEAR;
                    w_nextPtr   = '0;
                end
            end
            S_CLEAR: begin
                w_nextPtr = r_clearPtr + 1'b1;
                if (r_clearPtr == {ADDR_SIZE{1'b1}}) begin
                    w_nextState = S_IDLE;
                end
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    assign busy   = (r_state == S_CLEAR);
    assign w_accA = en_A & ~busy;
    assign w_accB = en_B & ~busy;
    assign w_wrA  = w_accA & w_e_A;
    assign w_oldA = r_mem[addr_A];
    assign w_oldB = r_mem[addr_B];

    always_comb begin
        w_mergedA = w_oldA;
        for (int i = 0; i < NBYTES; i++) begin
            if (be_A[i]) begin
                w_mergedA[8*i +: 8] = data_in_A[8*i +: 8];
            end
        end
    end

    // New-data mode forwards the merged word to any same-address reader in the write cycle.
    assign w_rdA = (RDW_MODE != 0 && w_wrA) ? w_mergedA : w_oldA;
    assign w_rdB = (RDW_MODE != 0 && w_wrA && addr_B == addr_A) ? w_mergedA : w_oldB;

    always_ff @(posedge clk) begin
        if (busy) begin
            r_mem[r_clearPtr] <= '0;
        end else if (w_wrA) begin
            r_mem[addr_A] <= w_mergedA;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_validA1 <= 1'b0;
            r_validB1 <= 1'b0;
            r_dataA1  <= '0;
            r_dataB1  <= '0;
        end else begin
            r_validA1 <= w_accA;
            r_validB1 <= w_accB;
            if (w_accA) begin
                r_dataA1 <= w_rdA;
            end
            if (w_accB) begin
                r_dataB1 <= w_rdB;
            end
        end
    end

    if (RD_LATENCY == 2) begin : g_lat2
        logic                 r_validA2;
        logic                 r_validB2;
        logic [DATA_SIZE-1:0] r_dataA2;
        logic [DATA_SIZE-1:0] r_dataB2;

        // Output stage always advances; data only moves with a valid so it holds otherwise.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_validA2 <= 1'b0;
                r_validB2 <= 1'b0;
                r_dataA2  <= '0;
                r_dataB2  <= '0;
            end else begin
                r_validA2 <= r_validA1;
                r_validB2 <= r_validB1;
                if (r_validA1) begin
                    r_dataA2 <= r_dataA1;
                end
                if (r_validB1) begin
                    r_dataB2 <= r_dataB1;
                end
            end
        end

        assign data_out_A = r_dataA2;
        assign valid_A    = r_validA2;
        assign data_out_B = r_dataB2;
        assign valid_B    = r_validB2;
    end else begin : g_lat1
        assign data_out_A = r_dataA1;
        assign valid_A    = r_validA1;
        assign data_out_B = r_dataB1;
        assign valid_B    = r_validB1;
    end

endmodule

// File: tb/tb_ram_dp_be.sv
// Randomized self-checking bench for ram_dp_be: one old-data/latency-1 instance and one
// new-data/latency-2 instance share the stimulus and are compared to a word-level array model.
module tb_ram_dp_be;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int NB    = DW / 8;
    localparam int DEPTH = 2 ** AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          clear;
    logic          en_A;
    logic          w_e_A;
    logic [NB-1:0] be_A;
    logic [AW-1:0] addr_A;
    logic [DW-1:0] data_in_A;
    logic          en_B;
    logic [AW-1:0] addr_B;

    logic          busy0, busy1;
    logic [DW-1:0] dataA0, dataB0, dataA1, dataB1;
    logic          validA0, validB0, validA1, validB1;

    int checks = 0;
    int errors = 0;

    // Behavioural model: word array, remaining clear cycles, and per-instance expected outputs.
    logic [DW-1:0] mMem [DEPTH];
    int            clearLeft;
    logic [DW-1:0] expDA0, expDB0, expDA1, expDB1;
    logic          pendVA1, pendVB1;
    logic [DW-1:0] pendDA1, pendDB1;

    always #5 clk = ~clk;

    ram_dp_be #(.ADDR_SIZE(AW), .DATA_SIZE(DW), .RD_LATENCY(1), .RDW_MODE(0), .CLEAR_ON_RESET(1)) dut0 (
        .clk(clk), .reset(reset), .clear(clear), .busy(busy0),
        .en_A(en_A), .w_e_A(w_e_A), .be_A(be_A), .addr_A(addr_A), .data_in_A(data_in_A),
        .data_out_A(dataA0), .valid_A(validA0),
        .en_B(en_B), .addr_B(addr_B), .data_out_B(dataB0), .valid_B(validB0)
    );

    ram_dp_be #(.ADDR_SIZE(AW), .DATA_SIZE(DW), .RD_LATENCY(2), .RDW_MODE(1), .CLEAR_ON_RESET(1)) dut1 (
        .clk(clk), .reset(reset), .clear(clear), .busy(busy1),
        .en_A(en_A), .w_e_A(w_e_A), .be_A(be_A), .addr_A(addr_A), .data_in_A(data_in_A),
        .data_out_A(dataA1), .valid_A(validA1),
        .en_B(en_B), .addr_B(addr_B), .data_out_B(dataB1), .valid_B(validB1)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [DW-1:0] mergeWord(input logic [DW-1:0] oldWord, input logic [DW-1:0] newWord,
                                                input logic [NB-1:0] enables);
        logic [DW-1:0] result;
        result = oldWord;
        for (int i = 0; i < NB; i++) begin
            if (enables[i]) result[8*i +: 8] = newWord[8*i +: 8];
        end
        return result;
    endfunction

    // After reset the array will be zero-filled before any access can be accepted.
    task automatic modelReset();
        clearLeft = DEPTH;
        for (int i = 0; i < DEPTH; i++) mMem[i] = '0;
        expDA0 = '0; expDB0 = '0; expDA1 = '0; expDB1 = '0;
        pendVA1 = 1'b0; pendVB1 = 1'b0; pendDA1 = '0; pendDB1 = '0;
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then check both instances.
    task automatic applyStimulus(input logic enA, input logic we, input logic [NB-1:0] be,
                                 input logic [AW-1:0] aA, input logic [DW-1:0] dIn,
                                 input logic enB, input logic [AW-1:0] aB, input logic clr);
        logic          busyNow, accA, accB, wr;
        logic [DW-1:0] oldA, oldB, merged, rdA1, rdB1;
        logic          expVA1, expVB1;
        en_A = enA; w_e_A = we; be_A = be; addr_A = aA; data_in_A = dIn;
        en_B = enB; addr_B = aB; clear = clr;

        busyNow = (clearLeft > 0);
        accA    = enA && !busyNow;
        accB    = enB && !busyNow;
        wr      = accA && we;
        oldA    = mMem[aA];
        oldB    = mMem[aB];
        merged  = mergeWord(oldA, dIn, be);
        rdA1    = wr ? merged : oldA;
        rdB1    = (wr && aB == aA) ? merged : oldB;

        if (wr) mMem[aA] = merged;
        if (busyNow) begin
            clearLeft--;
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) mMem[i] = '0;
            clearLeft = DEPTH;
        end

        if (accA) expDA0 = oldA;
        if (accB) expDB0 = oldB;
        expVA1 = pendVA1;
        expVB1 = pendVB1;
        if (pendVA1) expDA1 = pendDA1;
        if (pendVB1) expDB1 = pendDB1;
        pendVA1 = accA; pendDA1 = rdA1;
        pendVB1 = accB; pendDB1 = rdB1;

        @(posedge clk);
        #1;
        checkOutput("busy0",   32'(busy0),   32'(clearLeft > 0));
        checkOutput("busy1",   32'(busy1),   32'(clearLeft > 0));
        checkOutput("validA0", 32'(validA0), 32'(accA));
        checkOutput("validB0", 32'(validB0), 32'(accB));
        checkOutput("dataA0",  dataA0,       expDA0);
        checkOutput("dataB0",  dataB0,       expDB0);
        checkOutput("validA1", 32'(validA1), 32'(expVA1));
        checkOutput("validB1", 32'(validB1), 32'(expVB1));
        checkOutput("dataA1",  dataA1,       expDA1);
        checkOutput("dataB1",  dataB1,       expDB1);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
    endtask

    // Steps idle cycles until busy drops, bounded so a stuck sequencer cannot hang the run.
    task automatic waitClearDone(output int cycles);
        cycles = 0;
        while (busy0 && cycles < 40) begin
            idleCycle();
            cycles++;
        end
    endtask

    task automatic readAllZero(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1, AW'(i), 1'b0);
            checkOutput(tag, dataB0, 32'h0);
        end
        idleCycle();
    endtask

    initial begin
        int cycles;
        reset = 1'b1; clear = 1'b0; en_A = 1'b0; w_e_A = 1'b0; be_A = '0;
        addr_A = '0; data_in_A = '0; en_B = 1'b0; addr_B = '0;
        modelReset();
        @(negedge clk);
        @(negedge clk);
        checkOutput("rstBusy",   32'(busy0),   32'h1);
        checkOutput("rstValidB", 32'(validB0), 32'h0);
        checkOutput("rstDataA1", dataA1,       32'h0);
        reset = 1'b0;

        // Power-up clear runs 16 cycles, then every word reads back zero.
        waitClearDone(cycles);
        checkOutput("resetClearLen", 32'(cycles), 32'd16);
        readAllZero("t1Zero");

        // Byte-enable merge on port A, observed through port B.
        applyStimulus(1'b1, 1'b1, 4'b1111, 4'd3, 32'hDEADBEEF, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, 1'b1, 4'b0101, 4'd3, 32'h11223344, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1, 4'd3, 1'b0);
        checkOutput("beMerge0", dataB0, 32'hDE22BE44);
        idleCycle();
        checkOutput("beMerge1", dataB1, 32'hDE22BE44);

        // Read during write: old data at latency 1, new data at latency 2.
        applyStimulus(1'b1, 1'b1, 4'b1111, 4'd5, 32'hAAAAAAAA, 1'b0, '0, 1'b0);
        idleCycle();
        applyStimulus(1'b1, 1'b1, 4'b1111, 4'd5, 32'h55555555, 1'b1, 4'd5, 1'b0);
        checkOutput("rdwOldA", dataA0, 32'hAAAAAAAA);
        checkOutput("rdwOldB", dataB0, 32'hAAAAAAAA);
        checkOutput("lat2NotYet", 32'(validB1), 32'h0);
        idleCycle();
        checkOutput("rdwNewA", dataA1, 32'h55555555);
        checkOutput("rdwNewB", dataB1, 32'h55555555);
        checkOutput("lat2Valid", 32'(validB1), 32'h1);

        // Back-to-back reads at latency 2 give one valid per cycle.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b1, AW'(i), 1'b0);
            if (i > 0) checkOutput("lat2Stream", 32'(validB1), 32'h1);
        end
        idleCycle();

        // Random traffic with frequent address collisions and occasional clears.
        for (int n = 0; n < 400; n++) begin
            logic [AW-1:0] aA;
            aA = AW'($urandom_range(0, DEPTH - 1));
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0, NB'($urandom_range(0, 15)),
                          aA, $urandom, $urandom_range(0, 3) != 0,
                          ($urandom_range(0, 1) != 0) ? aA : AW'($urandom_range(0, DEPTH - 1)),
                          $urandom_range(0, 59) == 0);
        end
        waitClearDone(cycles);

        // Clear with port A hammering writes and a second clear mid-sequence.
        applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
        cycles = 0;
        while (busy0 && cycles < 40) begin
            applyStimulus(1'b1, 1'b1, 4'b1111, AW'($urandom_range(0, DEPTH - 1)), $urandom,
                          1'b1, AW'($urandom_range(0, DEPTH - 1)), cycles == 5);
            checkOutput("clrNoValidA", 32'(validA0), 32'h0);
            cycles++;
        end
        checkOutput("clearLen", 32'(cycles), 32'd16);
        idleCycle();
        readAllZero("t5Zero");

        // Reset in the middle of a clear restarts the full sequence.
        applyStimulus(1'b1, 1'b1, 4'b1111, 4'd7, 32'h12345678, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, 1'b0, '0, 4'd7, '0, 1'b1, 4'd7, 1'b0);
        applyStimulus(1'b0, 1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 6; i++) idleCycle();
        reset = 1'b1;
        #1;
        checkOutput("midRstDataA0", dataA0, 32'h0);
        checkOutput("midRstDataB0", dataB0, 32'h0);
        checkOutput("midRstDataA1", dataA1, 32'h0);
        checkOutput("midRstDataB1", dataB1, 32'h0);
        checkOutput("midRstValid",  32'({validA0, validB0, validA1, validB1}), 32'h0);
        checkOutput("midRstBusy",   32'(busy0), 32'h1);
        modelReset();
        @(negedge clk);
        reset = 1'b0;
        waitClearDone(cycles);
        checkOutput("restartClearLen", 32'(cycles), 32'd16);
        readAllZero("t6Zero");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
